// File: rtl/vendor_input.sv
// vendor_input: input conditioner in front of the vending-machine FSM.
//
// Debounces the three raw button lines (coin, coffee, sprite), turns each
// accepted press into a pending request, and serialises the requests into
// single-cycle pulses with fixed priority c > f > p. This guarantees the FSM
// sees at most one request per clock.
//
// Parameters
//   DB_CYCLES  consecutive differing samples needed to accept a new level
//              (legal range 1..255)
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-low reset
//   btn_c      raw coin line, active-high, may bounce
//   btn_f      raw coffee-select line, active-high, may bounce
//   btn_p      raw sprite-select line, active-high, may bounce
//   c, f, p    registered one-cycle request pulses (at most one high)
//   pend       registered pending-request bits {p,f,c}
//   busy       OR of pend
//
// Build option
//   VENDOR_INPUT_SYNC_EN  when defined, each btn_* passes through a two-flop
//                         synchroniser ahead of the debouncer (+2 cycles of
//                         latency). Leave it undefined only when the buttons
//                         are already synchronous to clk.

module vendor_input #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_c,
   input  logic       btn_f,
   input  logic       btn_p,
   output logic       c,
   output logic       f,
   output logic       p,
   output logic [2:0] pend,
   output logic       busy
);

   // Terminal count: the sample that makes DB_CYCLES consecutive differing
   // samples is the one that is accepted.
   localparam logic [7:0] TC = 8'(DB_CYCLES - 1);

   logic [2:0] w_raw;
   logic [2:0] w_in;
   logic [2:0] w_accept;
   logic [2:0] w_press;
   logic [2:0] w_grant;

   logic [2:0] r_s;
   logic [7:0] r_cnt [3];
   logic [2:0] r_pend;
   logic [2:0] r_pulse;

   // Bit order {p,f,c} throughout, so index 0 is the highest priority.
   assign w_raw = {btn_p, btn_f, btn_c};

`ifdef VENDOR_INPUT_SYNC_EN
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_in = r_sync2;
`else
   assign w_in = w_raw;
`endif

   always_comb begin
      w_accept = '0;
      w_press  = '0;
      for (int i = 0; i < 3; i++) begin
         w_accept[i] = (w_in[i] != r_s[i]) && (r_cnt[i] == TC);
         // Only a 0->1 accept is a press; releases set nothing.
         w_press[i]  = w_accept[i] & w_in[i];
      end
   end

   // Fixed-priority grant from the current pending bits.
   always_comb begin
      w_grant = 3'b000;
      if (r_pend[0]) begin
         w_grant = 3'b001;
      end else if (r_pend[1]) begin
         w_grant = 3'b010;
      end else if (r_pend[2]) begin
         w_grant = 3'b100;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s     <= '0;
         r_pend  <= '0;
         r_pulse <= '0;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_in[i] == r_s[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_s[i]   <= w_in[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
         // A press landing on the edge its own bit is granted keeps the bit
         // set, so a second pulse follows. A press on an already-pending,
         // ungranted channel simply merges (dropped).
         r_pend  <= (r_pend & ~w_grant) | w_press;
         r_pulse <= w_grant;
      end
   end

   assign c    = r_pulse[0];
   assign f    = r_pulse[1];
   assign p    = r_pulse[2];
   assign pend = r_pend;
   assign busy = |r_pend;

endmodule

// File: doc/vendor_input.md
# vendor_input

Input conditioner that sits directly upstream of the vending-machine FSM. It debounces three raw button lines: coin, coffee select and sprite select. Each debounced press becomes a single-cycle pulse on `c`, `f` or `p`, which the FSM samples once per clock. Simultaneous presses are serialised by fixed priority, so the FSM never sees more than one request per cycle.

## Interface
- `DB_CYCLES`, default 4: consecutive cycles a raw level must differ from the debounced level before it is accepted. Legal range is 1..255.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `btn_c` input 1: raw coin-insert line, active-high, may bounce.
- `btn_f` input 1: raw coffee-select line, active-high, may bounce.
- `btn_p` input 1: raw sprite-select line, active-high, may bounce.
- `c` output 1: one-cycle coin pulse to the FSM, registered.
- `f` output 1: one-cycle coffee pulse to the FSM, registered.
- `p` output 1: one-cycle sprite pulse to the FSM, registered.
- `pend` output 3: pending-request bits `{p,f,c}`, registered.
- `busy` output 1: OR of `pend`.

## Operation
- **Per-channel state.** Each channel has a debounced level `s`, an 8-bit counter `cnt` and a pending bit.
- **Debounce rule.** The debounce input is `in`: the raw line, or the synchronised line when the Configuration macro is defined.
  - If `in == s` on an edge: `cnt <= 0`.
  - If `in != s` and `cnt == DB_CYCLES-1`: `s <= in` and `cnt <= 0`.
  - If `in != s` otherwise: `cnt <= cnt+1`.
  - Any single-cycle return to `s` restarts the count.
- **Press detect.** An accept edge where `s` goes 0→1 sets that channel's pending bit.
  - A 1→0 transition (release) sets nothing.
- **Arbiter.** On every edge, the highest-priority set pending bit is cleared and its output is driven high for exactly one cycle.
  - Priority order: `c` > `f` > `p`.
  - All other outputs are 0 that cycle.
  - At most one of `c`, `f`, `p` is ever high.
- **Set/clear collision.** If a channel's pending bit is being granted on the same edge as a new press on that channel, set wins: the bit stays 1 and a second pulse follows.
- **Overflow.** A press on a channel whose pending bit is already set and not being granted is dropped; no counting, no error.
- **Stuck button.** A held button produces exactly one pulse. The next pulse requires a release accepted for `DB_CYCLES` cycles, then a new press.
- **Reset.** While `reset == 0` at an edge:
  - `s`, `cnt`, pending bits, synchroniser flops, `c`, `f`, `p`, `pend` and `busy` are all cleared to 0.
  - A button held through reset release is treated as a fresh press, because `s` restarts at 0.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- Edge 1 is the first rising edge at which `in` samples a new level.
- **Accept.** `s` changes at edge `DB_CYCLES`; the pending bit sets at that same edge.
- **Press latency, uncontested, no synchroniser.** The output pulse is high from edge `DB_CYCLES+1` to edge `DB_CYCLES+2`.
- **Synchroniser.** Adds 2 cycles to the above latency when compiled in.
- **Contention.** Simultaneous accepts on all three channels give pulses on consecutive cycles: `c`, then `f`, then `p`.
- **Back-to-back pulses.** The minimum spacing between two pulses on one channel is `2*DB_CYCLES` cycles: release accept plus press accept.

## Configuration
- Macro: `VENDOR_INPUT_SYNC_EN`.
- **Defined:** each `btn_*` passes through a two-flop synchroniser before debounce. Both flops reset to 0, and end-to-end latency is `DB_CYCLES+3` edges to pulse start.
- **Undefined:** `btn_*` drive debounce directly. Use only when inputs are already synchronous to `clk`; latency is `DB_CYCLES+1` edges.

## Test plan
All scenarios use `DB_CYCLES = 4` with `VENDOR_INPUT_SYNC_EN` undefined unless stated.
- **Reset:** hold `reset = 0` for 3 edges with all `btn_*` high → `c = f = p = 0`, `pend = 3'b000`, `busy = 0` throughout. After release, `c` pulses once at edge 5 post-release.
- **Bounce rejection:** `btn_f` toggles 1,0,1,1,0,1,1,1,1 then holds high → no pulse until the final 4-high run. Then exactly one `f` pulse, one cycle after the accept edge; no further pulses while held.
- **Contention:** `btn_c`, `btn_f` and `btn_p` all rise on the same edge and are held → `c` at edge 5, `f` at edge 6, `p` at edge 7. `pend` steps 111 → 110 → 100 → 000.
- **Repeat press:** `btn_c` held for 6 cycles, low for 4, high for 6 → exactly two `c` pulses, the second exactly 10 cycles after the first.
- **Reset mid-debounce:** `btn_p` high for 3 cycles, then `reset = 0` for one edge while `btn_p` stays high → no pulse before 4 full post-reset cycles; one `p` pulse at post-reset edge 5.
- **Synchroniser:** repeat the uncontested-press case with `VENDOR_INPUT_SYNC_EN` defined → the pulse appears 2 cycles later than without the macro. Pulse width is still 1 cycle.
